pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage pipeline. Generates the per-stage enable and active-low clear strobes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC register. It detects load-use hazards and branch mispredicts, freezes the pipe on data-memory wait, and handles halt/resume with a small FSM. It also keeps saturating stall and flush statistics counters.

---
 rtl/pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Produces per-stage enables and active-low clears (clear overrides enable
// in the stage registers), detects load-use and branch-mispredict hazards,
// freezes on data-memory wait with a timeout, and handles halt/resume.
// Stage strobes are combinational; FSM, wait counter and statistics are registered.
module pipeline_hazard_ctrl #(
   parameter int RW          = 5,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RW-1:0]    id_rs,
   input  logic [RW-1:0]    id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [RW-1:0]    ex_rd,
   input  logic             ex_regfile_w_en,
   input  logic             ex_r_datamem,
   input  logic             ex_is_branch,
   input  logic             ex_taken,
   input  logic             ex_pred_taken,
   input  logic             mem_busy,
   input  logic             halt_req,
   input  logic             resume,
   output logic             en_pc,
   output logic             en_ifid,
   output logic             en_idex,
   output logic             en_exmem,
   output logic             en_memwb,
   output logic             clear_ifid_n,
   output logic             clear_idex_n,
   output logic             clear_exmem_n,
   output logic             clear_memwb_n,
   output logic             redirect,
   output logic             halted,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;
   logic              err_q, err_d;
   logic              load_use_s;
   logic              mispredict_s;
   logic              run_eval_s;

   // Hazard detection terms; r0 is never a real dependency.
   always_comb begin
      load_use_s   = ex_r_datamem & ex_regfile_w_en & (ex_rd != {RW{1'b0}}) &
                     ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
      mispredict_s = ex_is_branch & (ex_taken != ex_pred_taken);
   end

   // Next-state, counter update and stage strobe generation.
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      stall_d       = stall_q;
      flush_d       = flush_q;
      err_d         = err_q;
      run_eval_s    = 1'b0;
      en_pc         = 1'b1;
      en_ifid       = 1'b1;
      en_idex       = 1'b1;
      en_exmem      = 1'b1;
      en_memwb      = 1'b1;
      clear_ifid_n  = 1'b1;
      clear_idex_n  = 1'b1;
      clear_exmem_n = 1'b1;
      clear_memwb_n = 1'b1;
      redirect      = 1'b0;
      halted        = 1'b0;

      case (state_q)
         ST_RUN: begin
            run_eval_s = 1'b1;
         end
         ST_MEM_WAIT: begin
            if (mem_busy) begin
               {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
               if (wait_q >= WC_W'(MEM_TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
                  wait_d  = {WC_W{1'b0}};
               end else begin
                  wait_d = wait_q + WC_W'(1);
               end
            end else begin
               // Memory released: the held instructions resolve this cycle.
               run_eval_s = 1'b1;
            end
         end
         ST_HALTED: begin
            halted = 1'b1;
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
            if (resume) begin
               clear_memwb_n = 1'b0;
               state_d       = ST_RUN;
            end else begin
               state_d = ST_HALTED;
            end
         end
         default: begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
            state_d = ST_RUN;
            wait_d  = {WC_W{1'b0}};
         end
      endcase

      if (run_eval_s) begin
         state_d = ST_RUN;
         wait_d  = {WC_W{1'b0}};
         if (halt_req) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
            state_d = ST_HALTED;
         end else if (mem_busy) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
            state_d = ST_MEM_WAIT;
            wait_d  = WC_W'(1);
         end else if (mispredict_s) begin
            redirect     = 1'b1;
            clear_ifid_n = 1'b0;
            clear_idex_n = 1'b0;
            flush_d      = (&flush_q) ? flush_q : flush_q + CNT_W'(1);
         end else if (load_use_s) begin
            en_pc        = 1'b0;
            en_ifid      = 1'b0;
            clear_idex_n = 1'b0;
            stall_d      = (&stall_q) ? stall_q : stall_q + CNT_W'(1);
         end else begin
            redirect = 1'b0;
         end
      end else begin
         run_eval_s = 1'b0;
      end

      if (rst) begin
         {en_pc, en_ifid, en_idex, en_exmem, en_memwb}              = 5'b00000;
         {clear_ifid_n, clear_idex_n, clear_exmem_n, clear_memwb_n} = 4'b0000;
         redirect = 1'b0;
         halted   = 1'b0;
      end else begin
         redirect = redirect;
      end
   end

   // State, wait counter, sticky error and statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         wait_q  <= {WC_W{1'b0}};
         stall_q <= {CNT_W{1'b0}};
         flush_q <= {CNT_W{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   assign stall_cnt       = stall_q;
   assign flush_cnt       = flush_q;
   assign mem_timeout_err = err_q;

endmodule
